// File: rtl/axioma_fetch_pkg.sv
// -----------------------------------------------------------------------------
// axioma_fetch_pkg
//   Shared definitions for the instruction prefetch unit: FSM state encoding,
//   default geometry and the instruction word type.
// -----------------------------------------------------------------------------
package axioma_fetch_pkg;

    // Default geometry
    localparam int DEPTH_DEF  = 4;
    localparam int ADDR_W_DEF = 16;

    // Instruction word; an empty queue presents this value on cpu_data
    typedef logic [15:0] instr_t;
    localparam instr_t NOP_WORD = 16'h0000;

    // Prefetch FSM encoding (kept as plain constants for legacy tools)
    localparam logic [1:0] ST_IDLE  = 2'b00;  // no request outstanding
    localparam logic [1:0] ST_BUSY  = 2'b01;  // live request, data will be kept
    localparam logic [1:0] ST_STALE = 2'b10;  // request outstanding, data will be dropped

endpackage : axioma_fetch_pkg

// File: rtl/axioma_fetch_fifo.sv
// -----------------------------------------------------------------------------
// axioma_fetch_fifo
//   Circular instruction buffer for the prefetch unit.
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   push, wdata   write one word at the tail (ignored when full)
//   pop           drop the head word (ignored when empty)
//   flush         empty the buffer; wins over push and pop in the same cycle
//   rdata         head word, NOP_WORD while empty
//   count         current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module axioma_fetch_fifo
    import axioma_fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [15:0]                  wdata,
    output logic [15:0]                  rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    instr_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && !flush && (count_q != FULL_CNT);
        do_pop   = pop  && !flush && (count_q != '0);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on their own
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; an empty buffer never exposes it
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = (count_q != '0) ? mem_q[rd_ptr_q] : NOP_WORD;
    assign count = count_q;

endmodule : axioma_fetch_fifo

// File: rtl/axioma_fetch_unit.sv
// -----------------------------------------------------------------------------
// axioma_fetch_unit
//   Instruction prefetch stage in front of the core's program-memory port.
//   Streams sequential word reads from Flash into a small queue and serves the
//   CPU from the queue head. A CPU address that is not the head address
//   flushes the queue and restarts prefetch from that address.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   fetch_en              allow new Flash requests (an outstanding one completes)
//   cpu_req, cpu_addr     CPU fetch request and word address
//   cpu_data, cpu_ready   head word; ready means it matches cpu_addr and is
//                         consumed at the clock edge
//   flash_req, flash_addr Flash request, held with a stable address until ack
//   flash_ack, flash_rdata single-cycle completion with read data
//   queue_count           queue occupancy (debug)
// -----------------------------------------------------------------------------
module axioma_fetch_unit
    import axioma_fetch_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        fetch_en,
    input  logic                        cpu_req,
    input  logic [ADDR_W-1:0]           cpu_addr,
    output logic [15:0]                 cpu_data,
    output logic                        cpu_ready,
    output logic                        flash_req,
    output logic [ADDR_W-1:0]           flash_addr,
    input  logic                        flash_ack,
    input  logic [15:0]                 flash_rdata,
    output logic [$clog2(DEPTH+1)-1:0]  queue_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] head_addr_q, head_addr_d;    // address of the queue head word
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;  // next address to request
    logic [ADDR_W-1:0] stale_addr_q, stale_addr_d;  // address of a request being discarded

    logic [CNT_W-1:0]  fifo_count;
    logic [15:0]       fifo_rdata;
    logic [CNT_W-1:0]  count_next;
    logic              hit, redirect, push, space;

    // -------------------------------------------------------------------------
    // CPU side: hit serves the head, anything else re-targets the stream.
    // A request for the head address while the queue is empty simply waits.
    // -------------------------------------------------------------------------
    always_comb begin
        hit      = cpu_req && (fifo_count != '0) && (cpu_addr == head_addr_q);
        redirect = cpu_req && !hit && ((fifo_count != '0) || (cpu_addr != head_addr_q));
        // Only a live request's data is kept; data arriving alongside a
        // redirect belongs to the old stream.
        push     = (state_q == ST_BUSY) && flash_ack && !redirect;
    end

    // Occupancy after this edge; a flush leaves the queue empty, so a redirect
    // always has room to restart immediately.
    always_comb begin
        if (redirect) count_next = '0;
        else          count_next = fifo_count + CNT_W'(push) - CNT_W'(hit);
        space = (count_next < FULL_CNT);
    end

    // -------------------------------------------------------------------------
    // Request FSM: at most one Flash request in flight, never withdrawn.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        stale_addr_d = stale_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (fetch_en && space) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (flash_ack) begin
                    // With a redirect this restarts at the new address with no gap
                    state_d = (fetch_en && space) ? ST_BUSY : ST_IDLE;
                end else if (redirect) begin
                    // Flash still owns the old address until it acks
                    state_d      = ST_STALE;
                    stale_addr_d = fetch_addr_q;
                end
            end
            ST_STALE: begin
                if (flash_ack) state_d = (fetch_en && space) ? ST_BUSY : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Address registers wrap modulo 2^ADDR_W
    always_comb begin
        head_addr_d  = head_addr_q;
        fetch_addr_d = fetch_addr_q;
        if (redirect) begin
            head_addr_d  = cpu_addr;
            fetch_addr_d = cpu_addr;
        end else begin
            if (hit)  head_addr_d  = head_addr_q  + ADDR_W'(1);
            if (push) fetch_addr_d = fetch_addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            head_addr_q  <= '0;
            fetch_addr_q <= '0;
            stale_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            head_addr_q  <= head_addr_d;
            fetch_addr_q <= fetch_addr_d;
            stale_addr_q <= stale_addr_d;
        end
    end

    axioma_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (hit),
        .flush   (redirect),
        .wdata   (flash_rdata),
        .rdata   (fifo_rdata),
        .count   (fifo_count)
    );

    assign flash_req   = (state_q != ST_IDLE);
    assign flash_addr  = (state_q == ST_STALE) ? stale_addr_q : fetch_addr_q;
    assign cpu_ready   = hit;
    assign cpu_data    = fifo_rdata;
    assign queue_count = fifo_count;

endmodule : axioma_fetch_unit

// File: tb/tb_axioma_fetch_unit.sv
module tb_axioma_fetch_unit;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_en;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_data;
    logic        cpu_ready;
    logic        flash_req;
    logic [15:0] flash_addr;
    logic        flash_ack;
    logic [15:0] flash_rdata;
    logic [2:0]  queue_count;

    always #5 clk = ~clk;

    axioma_fetch_unit #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .fetch_en    (fetch_en),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .cpu_ready   (cpu_ready),
        .flash_req   (flash_req),
        .flash_addr  (flash_addr),
        .flash_ack   (flash_ack),
        .flash_rdata (flash_rdata),
        .queue_count (queue_count)
    );

    int checks   = 0;
    int failures = 0;

    // Flash responder: latency fixed (>=0) or random 0..3 (-1)
    int   lat_mode  = 0;
    int   wait_left = -1;
    logic last_ready;

    // Reference model: queue contents, head/next addresses, in-flight request
    logic [15:0] mq[$];
    logic [15:0] m_head, m_fetch, m_req_addr;
    bit          m_active, m_discard;

    bit          found;
    logic [15:0] pc;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_head     = '0;
        m_fetch    = '0;
        m_req_addr = '0;
        m_active   = 1'b0;
        m_discard  = 1'b0;
    endfunction

    // Compare the DUT against the model for this cycle, then advance the model
    task automatic model_step();
        logic exp_ready, redirect, acked, took;
        if (!reset_n) begin
            check("rst_flash_req", flash_req, 0);
            check("rst_flash_addr", flash_addr, 0);
            check("rst_cpu_ready", cpu_ready, 0);
            check("rst_cpu_data", cpu_data, 0);
            check("rst_queue_count", queue_count, 0);
            model_reset();
            return;
        end
        exp_ready = cpu_req && (mq.size() > 0) && (cpu_addr == m_head);
        check("flash_req", flash_req, m_active);
        check("flash_addr", flash_addr, m_active ? m_req_addr : m_fetch);
        check("queue_count", queue_count, mq.size());
        check("cpu_ready", cpu_ready, exp_ready);
        if (exp_ready) check("cpu_data", cpu_data, mq[0]);

        redirect = cpu_req && !exp_ready && ((mq.size() > 0) || (cpu_addr != m_head));
        acked    = m_active && flash_ack;
        took     = acked && !m_discard && !redirect;
        if (redirect) begin
            mq.delete();
            m_head  = cpu_addr;
            m_fetch = cpu_addr;
        end else begin
            if (exp_ready) begin
                void'(mq.pop_front());
                m_head = m_head + 16'd1;
            end
            if (took) begin
                mq.push_back(flash_rdata);
                m_fetch = m_fetch + 16'd1;
            end
        end
        if (m_active && !acked) begin
            if (redirect) m_discard = 1'b1;
        end else begin
            m_active  = fetch_en && (mq.size() < DEPTH);
            m_discard = 1'b0;
            if (m_active) m_req_addr = m_fetch;
        end
    endtask

    // One clock cycle: Flash responds, model compares at negedge, return at posedge+1
    task automatic tick();
        if (reset_n && flash_req) begin
            if (wait_left < 0) wait_left = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            flash_ack = (wait_left == 0);
        end else begin
            flash_ack = 1'b0;
        end
        flash_rdata = flash_ack ? (16'hA000 + flash_addr) : 16'($urandom);
        @(negedge clk);
        model_step();
        last_ready = cpu_ready;
        @(posedge clk);
        #1;
        if (flash_ack || !reset_n) wait_left = -1;
        else if (wait_left > 0)    wait_left--;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        cpu_req   = 1'b0;
        fetch_en  = 1'b0;
        cpu_addr  = '0;
        flash_ack = 1'b0;
        repeat (2) tick();
        reset_n   = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b0;
        fetch_en    = 1'b0;
        cpu_req     = 1'b0;
        cpu_addr    = '0;
        flash_ack   = 1'b0;
        flash_rdata = '0;
        model_reset();

        // ---- Sequential stream with zero-wait Flash ----
        lat_mode = 0;
        do_reset();
        fetch_en = 1'b1;
        cpu_req  = 1'b1;
        cpu_addr = '0;
        #1;
        check("s1_rst_req", flash_req, 0);
        check("s1_rst_addr", flash_addr, 0);
        check("s1_rst_count", queue_count, 0);
        check("s1_rst_ready", cpu_ready, 0);
        check("s1_rst_data", cpu_data, 0);
        tick();
        check("s1_c1_req", flash_req, 1);
        check("s1_c1_addr", flash_addr, 0);
        check("s1_c1_ready", cpu_ready, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            cpu_addr = 16'(i);
            #1;
            check("s1_ready", cpu_ready, 1);
            check("s1_data", cpu_data, 16'hA000 + i);
            check("s1_faddr", flash_addr, i + 1);
            tick();
        end

        // ---- Prefetch fills the queue with no CPU demand ----
        lat_mode = 0;
        do_reset();
        fetch_en = 1'b1;
        cpu_req  = 1'b0;
        cpu_addr = '0;
        for (int i = 0; i < 7; i++) begin
            #1;
            if (i >= 1 && i <= 4) begin
                check("s2_req", flash_req, 1);
                check("s2_addr", flash_addr, i - 1);
            end else if (i >= 5) begin
                check("s2_idle_req", flash_req, 0);
                check("s2_full_count", queue_count, 4);
            end
            tick();
        end
        cpu_req  = 1'b1;
        cpu_addr = 16'h0000;
        #1;
        check("s2_hit_ready", cpu_ready, 1);
        check("s2_hit_data", cpu_data, 16'hA000);
        tick();
        cpu_req = 1'b0;
        #1;
        check("s2_refill_req", flash_req, 1);
        check("s2_refill_addr", flash_addr, 4);
        tick();
        #1;
        check("s2_refill_done", flash_req, 0);
        check("s2_refill_count", queue_count, 4);

        // ---- Jump while a 3-cycle request is outstanding ----
        lat_mode = 3;
        do_reset();
        fetch_en = 1'b1;
        cpu_req  = 1'b1;
        pc       = '0;
        found    = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            cpu_addr = pc;
            #1;
            if (flash_req && flash_addr == 16'h0002) found = 1'b1;
            else begin
                tick();
                if (last_ready) pc = pc + 16'd1;
            end
        end
        check("s3_reach_0002", found, 1);
        cpu_addr = 16'h0100;
        tick();
        check("s3_stale_req", flash_req, 1);
        check("s3_stale_addr", flash_addr, 16'h0002);
        check("s3_flushed", queue_count, 0);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            if (flash_req && flash_addr == 16'h0100) found = 1'b1;
            else tick();
        end
        check("s3_new_addr", found, 1);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            if (cpu_ready) found = 1'b1;
            else tick();
        end
        check("s3_ready_seen", found, 1);
        check("s3_data", cpu_data, 16'hA100);
        tick();

        // ---- Redirect in the same cycle as an ack ----
        lat_mode = 0;
        do_reset();
        fetch_en = 1'b1;
        cpu_req  = 1'b1;
        pc       = '0;
        for (int i = 0; i < 5; i++) begin
            cpu_addr = pc;
            tick();
            if (last_ready) pc = pc + 16'd1;
        end
        cpu_addr = 16'h0040;
        #1;
        check("s4_busy", flash_req, 1);
        check("s4_no_ready", cpu_ready, 0);
        tick();
        check("s4_nogap_req", flash_req, 1);
        check("s4_nogap_addr", flash_addr, 16'h0040);
        check("s4_dropped", queue_count, 0);
        tick();
        check("s4_ready", cpu_ready, 1);
        check("s4_data", cpu_data, 16'hA040);
        tick();

        // ---- Address wrap at 0xFFFF ----
        lat_mode = 0;
        do_reset();
        fetch_en = 1'b1;
        cpu_req  = 1'b1;
        cpu_addr = 16'hFFFF;
        tick();
        check("s5_req", flash_req, 1);
        check("s5_addr_ffff", flash_addr, 16'hFFFF);
        tick();
        check("s5_ready_ffff", cpu_ready, 1);
        check("s5_data_ffff", cpu_data, 16'h9FFF);
        check("s5_addr_0000", flash_addr, 16'h0000);
        tick();
        cpu_addr = 16'h0000;
        #1;
        check("s5_ready_0000", cpu_ready, 1);
        check("s5_data_0000", cpu_data, 16'hA000);
        tick();

        // ---- fetch_en drop during a request, then reset mid-request ----
        lat_mode = 3;
        do_reset();
        fetch_en = 1'b1;
        cpu_req  = 1'b0;
        cpu_addr = '0;
        tick();
        check("s6_req", flash_req, 1);
        check("s6_addr", flash_addr, 0);
        fetch_en = 1'b0;
        found    = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            tick();
            if (!flash_req) found = 1'b1;
        end
        check("s6_completed", found, 1);
        check("s6_pushed", queue_count, 1);
        repeat (3) begin
            tick();
            check("s6_hold", flash_req, 0);
        end
        fetch_en = 1'b1;
        tick();
        check("s6_resume_req", flash_req, 1);
        check("s6_resume_addr", flash_addr, 1);
        cpu_req  = 1'b1;
        cpu_addr = 16'h0000;
        #1;
        check("s6_pre_ready", cpu_ready, 1);
        check("s6_pre_data", cpu_data, 16'hA000);
        #1;
        reset_n = 1'b0;
        #1;
        check("s6_async_req", flash_req, 0);
        check("s6_async_addr", flash_addr, 0);
        check("s6_async_ready", cpu_ready, 0);
        check("s6_async_data", cpu_data, 0);
        check("s6_async_count", queue_count, 0);
        tick();

        // ---- Randomised traffic against the model ----
        lat_mode = -1;
        do_reset();
        pc = '0;
        for (int seg = 0; seg < 16; seg++) begin
            int req_pct;
            req_pct = (seg % 3 == 0) ? 30 : ((seg % 3 == 1) ? 75 : 95);
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 499) == 0) begin
                    do_reset();
                    pc = '0;
                end
                fetch_en = ($urandom_range(0, 9) != 0);
                cpu_req  = ($urandom_range(0, 99) < req_pct);
                if ($urandom_range(0, 99) < 6) begin
                    case ($urandom_range(0, 2))
                        0:       pc = 16'($urandom);
                        1:       pc = 16'hFFFC + 16'($urandom_range(0, 3));
                        default: pc = 16'($urandom_range(0, 15));
                    endcase
                end
                cpu_addr = pc;
                tick();
                if (last_ready) pc = pc + 16'd1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_axioma_fetch_unit

// File: doc/axioma_fetch_unit.md
Name: axioma_fetch_unit

Overview:
- Instruction prefetch stage directly upstream of the CPU core's program-memory interface.
- Issues sequential word requests to the program Flash over a req/ack handshake and buffers returned instructions in a small queue.
- Serves the CPU's fetch address from the queue head. Any fetch address that differs from the head address (jump, branch, rjmp) flushes the queue and restarts prefetch at the new address.

Parameters:
DEPTH, 4, queue entries (power of two, ≥2)
ADDR_W, 16, word-address width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
fetch_en  in  1  permits new Flash requests; 0 stops issuing (an outstanding request still completes)
cpu_req  in  1  CPU is in fetch and wants the word at cpu_addr
cpu_addr  in  ADDR_W  CPU program address (word)
cpu_data  out  16  instruction word at queue head
cpu_ready  out  1  cpu_data is valid for cpu_addr this cycle; the word is consumed at the clock edge
flash_req  out  1  Flash read request, held until flash_ack
flash_addr  out  ADDR_W  Flash word address, stable while flash_req=1
flash_ack  in  1  single-cycle completion; flash_rdata valid in the same cycle
flash_rdata  in  16  Flash read data
queue_count  out  $clog2(DEPTH+1)  current occupancy (debug)

Behaviour:
- Reset values: queue empty, head_addr=0, fetch_addr=0, state IDLE. Outputs: flash_req=0, flash_addr=0, cpu_ready=0, cpu_data=0, queue_count=0.
- hit = cpu_req && count>0 && cpu_addr==head_addr. cpu_ready=hit (combinational). cpu_data=head entry.
- On hit at the clock edge: pop the head; head_addr <= head_addr+1.
- redirect = cpu_req && !hit && (count>0 || cpu_addr!=head_addr).
- On redirect at the edge: flush the queue (count=0); head_addr <= cpu_addr; fetch_addr <= cpu_addr.
- cpu_req with empty queue and cpu_addr==head_addr is not a redirect. The unit waits.
- Address arithmetic: modulo 2^ADDR_W, so 0xFFFF+1 wraps to 0x0000.
- flash_req = (state!=IDLE). flash_addr = fetch_addr, held constant while flash_req=1 except as noted under STALE.
- A request is never withdrawn before its ack. At most one request is outstanding.
- space = (count + push - pop) < DEPTH, evaluated with this cycle's push and pop.
- State machine:
  - IDLE: if fetch_en && space → BUSY.
  - BUSY (live request): on flash_ack without redirect, push flash_rdata and set fetch_addr+1. Then go to BUSY if fetch_en && space, else IDLE.
  - BUSY, redirect without flash_ack → STALE.
  - BUSY, redirect with flash_ack in the same cycle → drop the data; BUSY at the new address.
  - STALE (outstanding request to be discarded): flash_addr keeps its old value until ack. A further redirect only updates the pending fetch_addr.
  - STALE on flash_ack: drop the data; go to BUSY if fetch_en, else IDLE.
- Push and pop in the same cycle: count unchanged. A push never occurs when the queue is full, guaranteed by the space check.
- Latency, zero-wait Flash (ack in the same cycle as req):
  - Redirect at edge N → flash_req in cycle N+1 → push at edge N+1 → cpu_ready in cycle N+2.
  - Steady state: 1 word per cycle.
- Reset mid-request: all state clears asynchronously. The Flash side must also be reset by the same reset_n.

Decomposition:
- Package axioma_fetch_pkg:
  - state encoding IDLE=2'b00, BUSY=2'b01, STALE=2'b10
  - default DEPTH and ADDR_W
  - NOP word 16'h0000
- Sub-module axioma_fetch_fifo:
  - circular buffer with push, pop and flush ports; rd/wr pointers $clog2(DEPTH) bits; count output.
  - Flush has priority over push in the same cycle.
- The top level holds the FSM, the head_addr/fetch_addr registers and the hit/redirect logic.

Test Plan:
- Reset, zero-wait Flash returning data = 16'hA000+addr, cpu_req=1 with the CPU incrementing cpu_addr from 0 → first cpu_ready in cycle 2; words A000, A001, A002… one per cycle; flash_addr 0,1,2…
- No cpu_req, Flash acks every cycle → flash requests for addr 0..3, queue_count=4, then flash_req=0. Then a hit at addr 0 → exactly one new request at addr 4.
- Flash with 3-cycle ack latency, cpu_addr jumps to 0x0100 while the request for 0x0002 is outstanding → STALE; 0x0002 data dropped; next flash_addr=0x0100; cpu_data=A100 on cpu_ready.
- Redirect in the same cycle as flash_ack → that data is never presented; flash_req continues at the new address with no gap.
- fetch_addr=0xFFFF, sequential fetch → flash_addr sequence FFFF, 0000; cpu_ready for cpu_addr=0x0000 after the wrap.
- fetch_en=0 during an outstanding request → ack completes and the data is pushed; flash_req then stays 0 until fetch_en=1. Assert reset_n mid-request → all outputs 0 immediately.
